// File: rtl/cdc_event_scheduler_if.sv
// Request/acknowledge handshake between the event scheduler and the shared consumer.
// The scheduler side is the master: it raises REQ_O with the granted source index on ID_O
// and waits for ACK_I from the consumer (slave side).
interface cdc_event_scheduler_if;
  logic       REQ_O;
  logic [2:0] ID_O;
  logic       ACK_I;

  modport master (output REQ_O, output ID_O, input ACK_I);
  modport slave  (input REQ_O, input ID_O, output ACK_I);
endinterface

// File: rtl/cdc_event_scheduler.sv
// Per-source pending event counters with a round-robin request/acknowledge scheduler
// towards a single shared consumer.
// Optional feature: define CDC_SCHED_DROP_CNT_EN to enable the saturating dropped-event
// counter on DROP_CNT_O. When it is not defined, DROP_CNT_O is tied to 0.
//
// state | meaning
// IDLE  | no request outstanding; picks a round-robin winner when any counter is non-zero
// REQ   | REQ_O high with ID_O held; returns to IDLE on ACK_I and moves the pointer
module cdc_event_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 3
) (
  input  logic                   CLK,
  input  logic                   strecher_reset,
  input  logic [NUM_SRC-1:0]     EVT_I,
  cdc_event_scheduler_if.master  bus,
  output logic [NUM_SRC-1:0]     PEND_O,
  output logic [NUM_SRC-1:0]     OVF_O,
  input  logic                   CLR_OVF_I,
  output logic [7:0]             DROP_CNT_O
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q;
  logic               req_q;
  logic [2:0]         id_q;
  logic [2:0]         ptr_q;

  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] ovf_q;
  logic [NUM_SRC-1:0] ovf_d;
  logic [NUM_SRC-1:0] dec;
  logic [NUM_SRC-1:0] hit;

  logic [NUM_SRC-1:0] rot;
  logic [3:0]         sum;
  logic               win_found;
  logic [2:0]         win_id;
  logic [2:0]         next_ptr;

  assign bus.REQ_O = req_q;
  assign bus.ID_O  = id_q;
  assign OVF_O     = ovf_q;

  // Pending flags decoded from the registered counters
  always_comb begin
    PEND_O = '0;
    for (int i = 0; i < NUM_SRC; i++) PEND_O[i] = |cnt_q[i];
  end

  // Round-robin winner: first pending source at or after ptr, wrapping modulo NUM_SRC
  always_comb begin
    rot       = NUM_SRC'({PEND_O, PEND_O} >> ptr_q);
    win_found = 1'b0;
    sum       = {1'b0, ptr_q};
    for (int off = 0; off < NUM_SRC; off++) begin
      if (!win_found && rot[off]) begin
        win_found = 1'b1;
        sum       = {1'b0, ptr_q} + 4'(off);
      end
    end
    win_id = (sum >= 4'(NUM_SRC)) ? 3'(sum - 4'(NUM_SRC)) : sum[2:0];
  end

  // Pointer moves just past the source whose grant completes
  always_comb begin
    next_ptr = (id_q == 3'(NUM_SRC - 1)) ? 3'd0 : id_q + 3'd1;
  end

  // Counter next-state: event and grant at the same edge cancel; saturation flags overflow
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      dec[i]   = req_q && bus.ACK_I && (id_q == 3'(i));
      hit[i]   = 1'b0;
      cnt_d[i] = cnt_q[i];
      if (EVT_I[i] && !dec[i]) begin
        if (cnt_q[i] == CNT_MAX) hit[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!EVT_I[i] && dec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    ovf_d = hit | (CLR_OVF_I ? '0 : ovf_q);
  end

  // Counter and sticky overflow registers
  always_ff @(posedge CLK or posedge strecher_reset) begin
    if (strecher_reset) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
      ovf_q <= ovf_d;
    end
  end

  // Two-state request FSM with registered REQ_O/ID_O and the round-robin pointer
  always_ff @(posedge CLK or posedge strecher_reset) begin
    if (strecher_reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      id_q    <= 3'd0;
      ptr_q   <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            id_q    <= win_id;
          end
        end
        S_REQ: begin
          if (bus.ACK_I) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            ptr_q   <= next_ptr;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CDC_SCHED_DROP_CNT_EN
  logic [7:0] drop_q;
  logic [7:0] drop_d;
  logic [8:0] drop_sum;

  // Several sources can drop in the same cycle, so add the whole hit count at once
  always_comb begin
    drop_sum = {1'b0, drop_q} + 9'($countones(hit));
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Saturating dropped-event counter
  always_ff @(posedge CLK or posedge strecher_reset) begin
    if (strecher_reset) drop_q <= 8'd0;
    else                drop_q <= drop_d;
  end

  assign DROP_CNT_O = drop_q;
`else
  assign DROP_CNT_O = 8'd0;
`endif

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Directed bench for cdc_event_scheduler (NUM_SRC=4, CNT_W=3). Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point, when registered state is settled.
module tb_cdc_event_scheduler;
  logic       CLK = 1'b0;
  logic       strecher_reset = 1'b1;
  logic [3:0] EVT_I = 4'b0000;
  logic       CLR_OVF_I = 1'b0;
  logic [3:0] PEND_O;
  logic [3:0] OVF_O;
  logic [7:0] DROP_CNT_O;

  int errors = 0;
  int checks = 0;
  int grants;

  cdc_event_scheduler_if bus();

  cdc_event_scheduler #(.NUM_SRC(4), .CNT_W(3)) dut (
    .CLK            (CLK),
    .strecher_reset (strecher_reset),
    .EVT_I          (EVT_I),
    .bus            (bus),
    .PEND_O         (PEND_O),
    .OVF_O          (OVF_O),
    .CLR_OVF_I      (CLR_OVF_I),
    .DROP_CNT_O     (DROP_CNT_O)
  );

  always #5 CLK = ~CLK;

`ifdef CDC_SCHED_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP = 8'd2;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.ACK_I = 1'b0;

    // reset state, before any clock edge
    #3;
    check("rst_req",  8'(bus.REQ_O), 8'd0);
    check("rst_id",   8'(bus.ID_O),  8'd0);
    check("rst_pend", 8'(PEND_O),    8'd0);
    check("rst_ovf",  8'(OVF_O),     8'd0);
    check("rst_drop", DROP_CNT_O,    8'd0);
    tick();
    tick();
    strecher_reset = 1'b0;
    tick();

    // ACK in IDLE with nothing pending must do nothing
    bus.ACK_I = 1'b1;
    tick();
    tick();
    check("idle_ack_req", 8'(bus.REQ_O), 8'd0);
    bus.ACK_I = 1'b0;

    // single event on source 0, ack in cycle 3
    EVT_I = 4'b0001;
    check("se_c0_req", 8'(bus.REQ_O), 8'd0);
    tick();
    EVT_I = 4'b0000;
    check("se_c1_req",  8'(bus.REQ_O), 8'd0);
    check("se_c1_pend", 8'(PEND_O),    8'h1);
    tick();
    check("se_c2_req", 8'(bus.REQ_O), 8'd1);
    check("se_c2_id",  8'(bus.ID_O),  8'd0);
    tick();
    check("se_c3_req", 8'(bus.REQ_O), 8'd1);
    check("se_c3_id",  8'(bus.ID_O),  8'd0);
    bus.ACK_I = 1'b1;
    tick();
    bus.ACK_I = 1'b0;
    check("se_c4_req",  8'(bus.REQ_O), 8'd0);
    check("se_c4_pend", 8'(PEND_O),    8'h0);

    // round robin from ptr=1: all four sources once, ACK held
    EVT_I = 4'b1111;
    bus.ACK_I = 1'b1;
    tick();
    EVT_I = 4'b0000;
    check("rr_c1_pend", 8'(PEND_O), 8'hF);
    tick();
    check("rr_g0_req", 8'(bus.REQ_O), 8'd1);
    check("rr_g0_id",  8'(bus.ID_O),  8'd1);
    tick();
    check("rr_gap0", 8'(bus.REQ_O), 8'd0);
    tick();
    check("rr_g1_req", 8'(bus.REQ_O), 8'd1);
    check("rr_g1_id",  8'(bus.ID_O),  8'd2);
    tick();
    check("rr_gap1", 8'(bus.REQ_O), 8'd0);
    tick();
    check("rr_g2_req", 8'(bus.REQ_O), 8'd1);
    check("rr_g2_id",  8'(bus.ID_O),  8'd3);
    tick();
    check("rr_gap2", 8'(bus.REQ_O), 8'd0);
    tick();
    check("rr_g3_req", 8'(bus.REQ_O), 8'd1);
    check("rr_g3_id",  8'(bus.ID_O),  8'd0);
    tick();
    check("rr_end_req",  8'(bus.REQ_O), 8'd0);
    check("rr_end_pend", 8'(PEND_O),    8'h0);
    bus.ACK_I = 1'b0;

    // overflow: 9 pulses on source 2, clear requested on the last (overflowing) pulse
    for (int p = 0; p < 9; p++) begin
      EVT_I = 4'b0100;
      CLR_OVF_I = (p == 8);
      if (p == 7) check("ovf_before_8", 8'(OVF_O), 8'h0);
      if (p == 8) check("ovf_after_8",  8'(OVF_O), 8'h4);
      tick();
    end
    EVT_I = 4'b0000;
    CLR_OVF_I = 1'b0;
    check("ovf_set_wins_clr", 8'(OVF_O),   8'h4);
    check("ovf_drop",         DROP_CNT_O,  EXP_DROP);
    check("ovf_req",          8'(bus.REQ_O), 8'd1);
    check("ovf_id",           8'(bus.ID_O),  8'd2);
    CLR_OVF_I = 1'b1;
    tick();
    CLR_OVF_I = 1'b0;
    check("ovf_cleared", 8'(OVF_O), 8'h0);

    // drain source 2: counter saturated at 7, so exactly 7 grants
    grants = 0;
    for (int c = 0; c < 40; c++) begin
      bus.ACK_I = bus.REQ_O;
      if (bus.REQ_O) grants++;
      tick();
    end
    bus.ACK_I = 1'b0;
    check("drain_grants", 8'(grants),      8'd7);
    check("drain_pend",   8'(PEND_O),      8'h0);
    check("drain_req",    8'(bus.REQ_O),   8'd0);

    // simultaneous event and grant on source 1 (ptr=3)
    EVT_I = 4'b0010;
    tick();
    EVT_I = 4'b0000;
    tick();
    check("sim_req", 8'(bus.REQ_O), 8'd1);
    check("sim_id",  8'(bus.ID_O),  8'd1);
    EVT_I = 4'b0010;
    bus.ACK_I = 1'b1;
    tick();
    EVT_I = 4'b0000;
    bus.ACK_I = 1'b0;
    check("sim_gap_req",  8'(bus.REQ_O), 8'd0);
    check("sim_gap_pend", 8'(PEND_O),    8'h2);
    tick();
    check("sim_rereq",    8'(bus.REQ_O), 8'd1);
    check("sim_rereq_id", 8'(bus.ID_O),  8'd1);
    bus.ACK_I = 1'b1;
    tick();
    bus.ACK_I = 1'b0;
    check("sim_done_pend", 8'(PEND_O), 8'h0);
    tick();
    check("sim_done_req", 8'(bus.REQ_O), 8'd0);

    // wrap-around: ptr=2, sources 0 and 3 pending -> 3 first, then 0
    EVT_I = 4'b1001;
    bus.ACK_I = 1'b1;
    tick();
    EVT_I = 4'b0000;
    tick();
    check("wrap_g0_id", 8'(bus.ID_O), 8'd3);
    tick();
    tick();
    check("wrap_g1_req", 8'(bus.REQ_O), 8'd1);
    check("wrap_g1_id",  8'(bus.ID_O),  8'd0);
    tick();
    bus.ACK_I = 1'b0;
    check("wrap_pend", 8'(PEND_O), 8'h0);

    // reset mid-request with cnt[3]=3
    EVT_I = 4'b1000;
    tick();
    tick();
    tick();
    EVT_I = 4'b0000;
    check("mid_req",  8'(bus.REQ_O), 8'd1);
    check("mid_id",   8'(bus.ID_O),  8'd3);
    check("mid_pend", 8'(PEND_O),    8'h8);
    #2;
    strecher_reset = 1'b1;
    #1;
    check("arst_req",  8'(bus.REQ_O), 8'd0);
    check("arst_id",   8'(bus.ID_O),  8'd0);
    check("arst_pend", 8'(PEND_O),    8'h0);
    check("arst_ovf",  8'(OVF_O),     8'h0);
    check("arst_drop", DROP_CNT_O,    8'd0);
    tick();
    strecher_reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post_rst_req", 8'(bus.REQ_O), 8'd0);
    end
    check("post_rst_pend", 8'(PEND_O), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
